// File: rtl/alu.sv
// Registered integer ALU: 16 operations on A/B, one-cycle latency, zero flag.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow output for ADD/SUB.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Opsel,
  output logic [WIDTH-1:0] ALUop,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             zero_flag
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_SLL   = 4'b0010,
    OP_SLT   = 4'b0011,
    OP_SLTU  = 4'b0100,
    OP_XOR   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_OR    = 4'b1000,
    OP_AND   = 4'b1001,
    OP_XNOR  = 4'b1010,
    OP_NOR   = 4'b1011,
    OP_PASSB = 4'b1100,
    OP_PASSA = 4'b1101,
    OP_SEQ   = 4'b1110,
    OP_SNE   = 4'b1111
  } op_e;

  op_e              op;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  assign op   = op_e'(Opsel);
  assign sh   = B[SHW-1:0];
  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    res_d = '0;
    case (op)
      OP_ADD:   res_d = sum;
      OP_SUB:   res_d = diff;
      OP_SLL:   res_d = A << sh;
      OP_SLT:   res_d = WIDTH'($signed(A) < $signed(B));
      OP_SLTU:  res_d = WIDTH'(A < B);
      OP_XOR:   res_d = A ^ B;
      OP_SRL:   res_d = A >> sh;
      OP_SRA:   res_d = $unsigned($signed(A) >>> sh);
      OP_OR:    res_d = A | B;
      OP_AND:   res_d = A & B;
      OP_XNOR:  res_d = ~(A ^ B);
      OP_NOR:   res_d = ~(A | B);
      OP_PASSB: res_d = B;
      OP_PASSA: res_d = A;
      OP_SEQ:   res_d = WIDTH'(A == B);
      OP_SNE:   res_d = WIDTH'(A != B);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      res_q  <= res_d;
      zero_q <= (res_d == '0);
    end
  end

  assign ALUop     = res_q;
  assign zero_flag = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    case (op)
      OP_ADD:  ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      OP_SUB:  ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=32); overflow checks under ALU_OVERFLOW_EN.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Opsel;
  logic [31:0] ALUop;
  logic        zero_flag;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int unsigned n_cmp;
  int unsigned n_err;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Opsel     (Opsel),
    .ALUop     (ALUop),
`ifdef ALU_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    @(negedge clk);
    A = a;
    B = b;
    Opsel = op;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_exp [16];

  initial begin
    n_cmp = 0;
    n_err = 0;
    sweep_exp = '{32'd54, 32'hFFFF_FFF6, 32'd22, 32'd1, 32'd1,
                  32'h36, 32'd22, 32'd22, 32'h36, 32'd0,
                  32'hFFFF_FFC9, 32'hFFFF_FFC9, 32'd32, 32'd22, 32'd0, 32'd1};

    rst_n = 1'b0;
    A = '0;
    B = '0;
    Opsel = '0;
    #12;
    check("rst_res", ALUop, 32'd0);
    check("rst_zf", {31'd0, zero_flag}, 32'd1);
`ifdef ALU_OVERFLOW_EN
    check("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(32'd22, 32'd32, 4'(i));
      check($sformatf("sweep%0d_res", i), ALUop, sweep_exp[i]);
      check($sformatf("sweep%0d_zf", i), {31'd0, zero_flag}, {31'd0, sweep_exp[i] == 32'd0});
`ifdef ALU_OVERFLOW_EN
      check($sformatf("sweep%0d_ovf", i), {31'd0, overflow}, 32'd0);
`endif
    end

    run_op(32'h8000_0000, 32'd31, 4'b0110);
    check("srl31", ALUop, 32'd1);
    run_op(32'h8000_0000, 32'd31, 4'b0111);
    check("sra31", ALUop, 32'hFFFF_FFFF);
    run_op(32'd1, 32'h21, 4'b0010);
    check("sll_b21", ALUop, 32'd2);
    run_op(32'd1, 32'd31, 4'b0010);
    check("sll31", ALUop, 32'h8000_0000);
    run_op(32'h1234_5678, 32'hFFFF_FFE0, 4'b0110);
    check("srl_sh0", ALUop, 32'h1234_5678);

    run_op(32'h8000_0000, 32'd0, 4'b0011);
    check("slt_min", ALUop, 32'd1);
    run_op(32'h8000_0000, 32'd0, 4'b0100);
    check("sltu_min", ALUop, 32'd0);
    run_op(32'hFFFF_FFFF, 32'd1, 4'b0011);
    check("slt_m1", ALUop, 32'd1);
    run_op(32'hFFFF_FFFF, 32'd1, 4'b0100);
    check("sltu_m1", ALUop, 32'd0);
    run_op(32'hFFFF_FFFF, 32'd1, 4'b1110);
    check("seq_ne", ALUop, 32'd0);
    check("seq_ne_zf", {31'd0, zero_flag}, 32'd1);
    run_op(32'd5, 32'd5, 4'b1110);
    check("seq_eq", ALUop, 32'd1);
    check("seq_eq_zf", {31'd0, zero_flag}, 32'd0);
    run_op(32'd5, 32'd5, 4'b0001);
    check("sub_eq", ALUop, 32'd0);
    check("sub_eq_zf", {31'd0, zero_flag}, 32'd1);

    run_op(32'd22, 32'd32, 4'b0000);
    @(negedge clk);
    Opsel = 4'b0001;
    #1;
    check("lat_hold", ALUop, 32'd54);
    @(posedge clk);
    #1;
    check("lat_upd", ALUop, 32'hFFFF_FFF6);

`ifdef ALU_OVERFLOW_EN
    run_op(32'h7FFF_FFFF, 32'd1, 4'b0000);
    check("ovf_add_res", ALUop, 32'h8000_0000);
    check("ovf_add", {31'd0, overflow}, 32'd1);
    run_op(32'h8000_0000, 32'd1, 4'b0001);
    check("ovf_sub_res", ALUop, 32'h7FFF_FFFF);
    check("ovf_sub", {31'd0, overflow}, 32'd1);
    run_op(32'h7FFF_FFFF, 32'd1, 4'b1001);
    check("ovf_and", {31'd0, overflow}, 32'd0);
    run_op(32'h7FFF_FFFF, 32'd1, 4'b0000);
`endif

    run_op(32'h0000_00F0, 32'h0000_000F, 4'b1000);
    check("pre_rst_res", ALUop, 32'h0000_00FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res", ALUop, 32'd0);
    check("mid_rst_zf", {31'd0, zero_flag}, 32'd1);
`ifdef ALU_OVERFLOW_EN
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd4, 4'b0000);
    check("post_rst_add", ALUop, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
